division_check_multiplier: RTL and testbench

- Sequential signed shift-add multiply-accumulate: result = quotient*divisor + remainder.
- Rebuilds the dividend from the outputs of the team's slow divider.
- Flags whether the rebuilt value equals the original dividend.
- Sits beside the divider as its inverse path. Used in self-checking benches and as an optional on-chip result checker.

---
 rtl/division_check_multiplier.sv | 79 +++++++
 tb/tb_division_check_multiplier.sv | 128 ++++++++++++
 2 files changed

// File: rtl/division_check_multiplier.sv
// division_check_multiplier: sequential signed shift-add quotient*divisor+remainder with dividend match flag
module division_check_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     quotient,
    input  logic [WIDTH-1:0]     divisor,
    input  logic [WIDTH-1:0]     remainder,
    input  logic [WIDTH-1:0]     dividend,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 match
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, MUL, FIX} state_t;
    state_t state, state_n;
    logic [2*WIDTH-1:0] mcand, acc, prod, sum;
    logic [WIDTH-1:0]   mplier, rem, dvd, abs_q, abs_d;
    logic [CW-1:0]      cnt;
    logic               neg;
    assign abs_q = quotient[WIDTH-1] ? -quotient : quotient;
    assign abs_d = divisor[WIDTH-1] ? -divisor : divisor;
    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (start ? MUL : IDLE) :
                  state == MUL  ? (cnt == CW'(WIDTH - 1) ? FIX : MUL) : IDLE;
        prod = neg ? -acc : acc;
        sum  = prod + {{WIDTH{rem[WIDTH-1]}}, rem};
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            rem    <= '0;
            dvd    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            match  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    mcand  <= {{WIDTH{1'b0}}, abs_q};
                    mplier <= abs_d;
                    neg    <= quotient[WIDTH-1] ^ divisor[WIDTH-1];
                    rem    <= remainder;
                    dvd    <= dividend;
                    acc    <= '0;
                    cnt    <= '0;
                    busy   <= 1'b1;
                end
                MUL: begin
                    acc    <= mplier[0] ? acc + mcand : acc;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
                FIX: begin
                    result <= sum;
                    match  <= sum == {{WIDTH{dvd[WIDTH-1]}}, dvd};
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_division_check_multiplier.sv
// tb_division_check_multiplier: per-cycle checks against a transaction-level arithmetic reference
module tb_division_check_multiplier;
    localparam int W = 16;
    logic clk = 1'b0;
    logic rst, start;
    logic [W-1:0] quotient, divisor, remainder, dividend;
    logic busy, done, match;
    logic [2*W-1:0] result;
    always #5 clk = ~clk;
    division_check_multiplier #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .quotient(quotient), .divisor(divisor),
        .remainder(remainder), .dividend(dividend), .busy(busy), .done(done),
        .result(result), .match(match)
    );
    int n_cmp = 0, n_err = 0, m_left = 0, n_done = 0, base;
    longint pend_res = 0, cur_res = 0;
    logic pend_m = 1'b0, cur_m = 1'b0, exp_done = 1'b0;
    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        exp_done = 1'b0;
        if (rst) begin
            m_left = 0;
            cur_res = 0;
            cur_m = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                exp_done = 1'b1;
                cur_res = pend_res;
                cur_m = pend_m;
                n_done++;
            end
        end else if (start) begin
            pend_res = longint'($signed(quotient)) * longint'($signed(divisor)) + longint'($signed(remainder));
            pend_m = pend_res == longint'($signed(dividend));
            m_left = W + 1;
        end
        #1;
        chk("busy", busy, m_left > 0);
        chk("done", done, exp_done);
        chk("result", $signed(result), cur_res);
        chk("match", match, cur_m);
    endtask
    task automatic cyc(input logic s, input logic [W-1:0] q, input logic [W-1:0] d,
                       input logic [W-1:0] r, input logic [W-1:0] dv);
        @(negedge clk);
        start = s;
        quotient = q;
        divisor = d;
        remainder = r;
        dividend = dv;
        step();
    endtask
    task automatic cyc_rand(input logic s);
        cyc(s, 16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()));
    endtask
    task automatic op(input logic [W-1:0] q, input logic [W-1:0] d, input logic [W-1:0] r, input logic [W-1:0] dv);
        cyc(1'b1, q, d, r, dv);
        for (int i = 0; i < W + 4 && m_left > 0; i++) cyc_rand($urandom_range(1) == 1);
    endtask
    initial begin
        rst = 1'b1;
        start = 1'b0;
        quotient = '0;
        divisor = '0;
        remainder = '0;
        dividend = '0;
        step();
        step();
        rst = 1'b0;
        cyc(1'b0, 0, 0, 0, 0);
        op(16'sd6, 16'sd5, 16'sd2, 16'sd32);
        chk("basic_res", $signed(result), 32);
        chk("basic_match", match, 1);
        op(-16'sd6, 16'sd5, -16'sd2, -16'sd32);
        chk("sign1_res", $signed(result), -32);
        chk("sign1_match", match, 1);
        op(16'sd6, -16'sd5, 16'sd2, -16'sd28);
        chk("sign2_res", $signed(result), -28);
        chk("sign2_match", match, 1);
        op(16'h8000, 16'h8000, 16'h0000, 16'h0000);
        chk("ext1_res", $signed(result), 1073741824);
        op(16'h8000, 16'h7fff, 16'hffff, 16'h0000);
        chk("ext2_res", $signed(result), -1073709057);
        op(16'sd6, 16'sd5, 16'sd2, 16'sd33);
        chk("mism_res", $signed(result), 32);
        chk("mism_match", match, 0);
        op(16'sd6, 16'sd0, -16'sd7, -16'sd7);
        chk("div0_res", $signed(result), -7);
        chk("div0_match", match, 1);
        base = n_done;
        for (int i = 0; i < 40; i++) cyc_rand(1'b1);
        for (int i = 0; i < W + 2 && m_left > 0; i++) cyc_rand(1'b0);
        chk("hs_done_count", n_done - base, 3);
        cyc(1'b1, 16'sd100, 16'sd7, 16'sd3, 16'sd703);
        for (int i = 0; i < 7; i++) cyc_rand(1'b0);
        rst = 1'b1;
        cyc_rand(1'b0);
        rst = 1'b0;
        chk("rst_res", $signed(result), 0);
        base = n_done;
        for (int i = 0; i < W + 8; i++) cyc_rand(1'b0);
        chk("rst_no_done", n_done - base, 0);
        op(16'sd100, 16'sd7, 16'sd3, 16'sd703);
        chk("post_rst_res", $signed(result), 703);
        chk("post_rst_match", match, 1);
        for (int k = 0; k < 30; k++) begin
            logic [W-1:0] q, d, r, dv;
            longint e;
            q = 16'($urandom());
            d = 16'($urandom_range(3) == 0 ? $urandom_range(3) : $urandom());
            r = 16'($urandom());
            e = longint'($signed(q)) * longint'($signed(d)) + longint'($signed(r));
            dv = $urandom_range(1) == 1 ? e[W-1:0] : 16'($urandom());
            op(q, d, r, dv);
            for (int i = 0; i < int'($urandom_range(2)); i++) cyc_rand(1'b0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
